// File: rtl/traffic_sensor_front.sv
// traffic_sensor_front
//   Vehicle-detector front end for the two-street traffic light controller.
//   Raw loop detectors are synchronized, debounced and latched into request
//   lines that stay high until the street's car light goes green. Also
//   tracks per-street wait time and raises a sticky fault on conflicting
//   light codes.
//
// Ports
//   CLK            clock, all state on rising edge
//   RST            synchronous active-high reset
//   RAW_A, RAW_B   asynchronous raw detectors (1 = vehicle present)
//   A, B           car light codes from controller: 00 red, 01 yellow, 10 green, 11 illegal
//   SA, SB         registered requests
//   WAIT_A, WAIT_B saturating count of edges the request has already been high
//   FAULT          sticky light-conflict flag, cleared only by RST

module traffic_sensor_front #(
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned WAIT_W   = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RAW_A,
    input  logic              RAW_B,
    input  logic [1:0]        A,
    input  logic [1:0]        B,
    output logic              SA,
    output logic              SB,
    output logic [WAIT_W-1:0] WAIT_A,
    output logic [WAIT_W-1:0] WAIT_B,
    output logic              FAULT
);

    localparam int unsigned CntW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CntW-1:0]   CntMax  = CntW'(DEBOUNCE - 1);
    localparam logic [WAIT_W-1:0] WaitMax = {WAIT_W{1'b1}};

    localparam logic [1:0] LightRed     = 2'b00;
    localparam logic [1:0] LightGreen   = 2'b10;
    localparam logic [1:0] LightIllegal = 2'b11;

    // Index 0 is street A, index 1 is street B.
    logic [1:0]        raw;
    logic [1:0]        light [2];

    logic [1:0]        sync1_q, sync1_d;
    logic [1:0]        sync2_q, sync2_d;
    logic [1:0]        filt_q,  filt_d;
    logic [CntW-1:0]   cnt_q    [2];
    logic [CntW-1:0]   cnt_d    [2];
    logic [1:0]        req_q,   req_d;
    logic [WAIT_W-1:0] wait_q   [2];
    logic [WAIT_W-1:0] wait_d   [2];
    logic              fault_q, fault_d;

    always_comb begin
        raw      = {RAW_B, RAW_A};
        light[0] = A;
        light[1] = B;

        for (int i = 0; i < 2; i++) begin
            sync1_d[i] = raw[i];
            sync2_d[i] = sync1_q[i];

            // Debounce: a differing sample must persist DEBOUNCE cycles in a row.
            filt_d[i] = filt_q[i];
            cnt_d[i]  = cnt_q[i];
            if (sync2_q[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                filt_d[i] = sync2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end

            // Green clears ahead of any set; yellow and illegal hold.
            req_d[i] = req_q[i];
            if (light[i] == LightGreen) begin
                req_d[i] = 1'b0;
            end else if (light[i] == LightRed && filt_q[i]) begin
                req_d[i] = 1'b1;
            end

            // Counts only edges where the request was already high, and drops to
            // zero on the same edge the request clears.
            if (req_d[i] && req_q[i]) begin
                wait_d[i] = (wait_q[i] == WaitMax) ? wait_q[i] : wait_q[i] + WAIT_W'(1);
            end else begin
                wait_d[i] = '0;
            end
        end

        fault_d = fault_q
                | ((A != LightRed) && (B != LightRed))
                | (A == LightIllegal)
                | (B == LightIllegal);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            req_q   <= '0;
            fault_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i]  <= '0;
                wait_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            req_q   <= req_d;
            fault_q <= fault_d;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i]  <= cnt_d[i];
                wait_q[i] <= wait_d[i];
            end
        end
    end

    assign SA     = req_q[0];
    assign SB     = req_q[1];
    assign WAIT_A = wait_q[0];
    assign WAIT_B = wait_q[1];
    assign FAULT  = fault_q;

endmodule

// File: tb/tb_traffic_sensor_front.sv
// Scoreboard bench for traffic_sensor_front (DEBOUNCE=3, WAIT_W=4).
// Each stimulus step pushes the hand-derived outputs expected after the next
// rising edge; a separate monitor pops and compares after every edge.

module tb_traffic_sensor_front;

    logic       clk = 1'b0;
    logic       rst;
    logic       raw_a, raw_b;
    logic [1:0] la, lb;
    logic       sa, sb, fault;
    logic [3:0] wait_a, wait_b;

    traffic_sensor_front #(
        .DEBOUNCE (3),
        .WAIT_W   (4)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .RAW_A  (raw_a),
        .RAW_B  (raw_b),
        .A      (la),
        .B      (lb),
        .SA     (sa),
        .SB     (sb),
        .WAIT_A (wait_a),
        .WAIT_B (wait_b),
        .FAULT  (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         e;
        logic       sa;
        logic       sb;
        logic [3:0] wa;
        logic [3:0] wb;
        logic       f;
    } exp_t;

    exp_t scb[$];
    int   edge_no = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    task automatic cmp(input string name, input int e, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL edge %0d %s: got %0d, want %0d", e, name, got, want);
        end
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            edge_no++;
            while (scb.size() > 0 && scb[0].e < edge_no) begin
                n_bad++;
                $display("FAIL edge %0d stale: expectation for edge %0d never checked",
                         edge_no, scb[0].e);
                void'(scb.pop_front());
            end
            if (scb.size() > 0 && scb[0].e == edge_no) begin
                exp_t x;
                x = scb.pop_front();
                cmp("SA",     edge_no, int'(sa),     int'(x.sa));
                cmp("SB",     edge_no, int'(sb),     int'(x.sb));
                cmp("WAIT_A", edge_no, int'(wait_a), int'(x.wa));
                cmp("WAIT_B", edge_no, int'(wait_b), int'(x.wb));
                cmp("FAULT",  edge_no, int'(fault),  int'(x.f));
            end
        end
    end

    // Drive inputs at a falling edge and expect the given outputs after the next rising edge.
    task automatic step(input logic rs, input logic ra, input logic rb,
                        input logic [1:0] a, input logic [1:0] b,
                        input logic esa, input logic esb,
                        input int ewa, input int ewb, input logic ef);
        exp_t x;
        x.e  = edge_no + 1;
        x.sa = esa;
        x.sb = esb;
        x.wa = 4'(ewa);
        x.wb = 4'(ewb);
        x.f  = ef;
        scb.push_back(x);
        rst   = rs;
        raw_a = ra;
        raw_b = rb;
        la    = a;
        lb    = b;
        @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        raw_a = 1'b0;
        raw_b = 1'b0;
        la    = 2'b00;
        lb    = 2'b00;
        @(negedge clk);

        // Reset and idle
        repeat (2)  step(1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        repeat (20) step(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);

        // Debounce accept on A: SA at edge 6, WAIT_A from edge 7, saturating at 15
        for (int k = 1; k <= 24; k++) begin
            int w;
            w = (k >= 6) ? ((k - 6 > 15) ? 15 : k - 6) : 0;
            step(0, 1, 0, 2'b00, 2'b00, k >= 6, 0, w, 0, 0);
        end

        // Vehicle leaves: request survives, counter stays saturated
        repeat (6) step(0, 0, 0, 2'b00, 2'b00, 1, 0, 15, 0, 0);
        // Green serves A on the same edge
        step(0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0, 0);
        // Vehicle arrives during green: no request
        repeat (8) step(0, 1, 0, 2'b10, 2'b00, 0, 0, 0, 0, 0);
        // Back to red: request on the first edge
        step(0, 1, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0);
        step(0, 1, 0, 2'b00, 2'b00, 1, 0, 1, 0, 0);
        step(0, 1, 0, 2'b00, 2'b00, 1, 0, 2, 0, 0);

        // Priority: yellow holds, green clears, yellow holds low, red sets
        step(0, 1, 0, 2'b01, 2'b00, 1, 0, 3, 0, 0);
        step(0, 1, 0, 2'b01, 2'b00, 1, 0, 4, 0, 0);
        step(0, 1, 0, 2'b10, 2'b00, 0, 0, 0, 0, 0);
        step(0, 1, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
        step(0, 1, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0);
        step(0, 1, 0, 2'b00, 2'b00, 1, 0, 1, 0, 0);

        // Park A on green, then glitch tests on B
        step(0, 1, 0, 2'b10, 2'b00, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++)
            step(0, 1, k <= 2, 2'b10, 2'b00, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++)
            step(0, 1, k <= 3, 2'b10, 2'b00, 0, k >= 6, 0, (k >= 6) ? k - 6 : 0, 0);

        // Fault: A green + B yellow, sticky through legal and illegal codes
        step(0, 1, 0, 2'b10, 2'b01, 0, 1, 0, 5, 1);
        step(0, 1, 0, 2'b00, 2'b00, 1, 1, 0, 6, 1);
        step(0, 1, 0, 2'b00, 2'b11, 1, 1, 1, 7, 1);
        step(0, 1, 0, 2'b00, 2'b10, 1, 0, 2, 0, 1);
        step(0, 1, 0, 2'b11, 2'b00, 1, 0, 3, 0, 1);
        // Reset clears everything; held detector re-accepted with full latency
        step(1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++)
            step(0, 1, 0, 2'b00, 2'b00, k >= 6, 0, (k >= 7) ? k - 6 : 0, 0, 0);

        for (int i = 0; i < 10 && scb.size() > 0; i++) @(posedge clk);
        #2;
        if (scb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", scb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
